// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / PC stage: IDLE -> REQ -> EXEC loop with next-PC selection.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the sticky misalign flag and HALT state.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instr,
   output logic        o_instr_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   input  logic        i_instr_done,
   input  logic        i_jump,
   input  logic        i_branch,
   input  logic        i_nequal,
   input  logic        i_jr,
   input  logic        i_bclt,
   input  logic        i_alu_zero,
   input  logic        i_fp_cond,
   input  logic [31:0] i_jr_target,
   output logic        o_misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2,
      S_HALT = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2
   } state_t;
`endif

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic        r_imem_req;
   logic        w_req_nxt;
   logic        r_instr_valid;
   logic        w_valid_nxt;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_branch_tgt;
   logic [31:0] w_jump_tgt;
   logic        w_taken;
   logic [31:0] w_next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        r_misalign;
   logic        w_misalign_nxt;
`endif

   assign w_pc_plus4   = r_pc + 32'd4;
   assign w_branch_tgt = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_jump_tgt   = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
   assign w_taken      = (i_branch & (i_alu_zero ^ i_nequal)) |
                         (i_bclt & (i_fp_cond == r_instr[16]));
   assign w_next_pc    = i_jr    ? i_jr_target :
                         i_jump  ? w_jump_tgt  :
                         w_taken ? w_branch_tgt : w_pc_plus4;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_req_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      w_misalign_nxt = r_misalign;
`endif
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
            w_req_nxt   = 1'b1;
         end
         S_REQ: begin
            if (i_imem_ack) begin
               w_instr_nxt = i_imem_rdata;
               w_state_nxt = S_EXEC;
               w_valid_nxt = 1'b1;
            end else begin
               w_req_nxt = 1'b1;
            end
         end
         S_EXEC: begin
            if (i_instr_done) begin
`ifdef FETCH_MISALIGN_TRAP_EN
               if (w_next_pc[1:0] != 2'b00) begin
                  w_misalign_nxt = 1'b1;
                  w_state_nxt    = S_HALT;
               end else begin
                  w_pc_nxt    = w_next_pc;
                  w_state_nxt = S_REQ;
                  w_req_nxt   = 1'b1;
               end
`else
               // Without the trap, low address bits are simply dropped.
               w_pc_nxt    = w_next_pc & 32'hFFFF_FFFC;
               w_state_nxt = S_REQ;
               w_req_nxt   = 1'b1;
`endif
            end else begin
               w_valid_nxt = 1'b1;
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_instr       <= 32'h0000_0000;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_misalign    <= 1'b0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_imem_req    <= w_req_nxt;
         r_instr_valid <= w_valid_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_misalign    <= w_misalign_nxt;
`endif
      end
   end

   assign o_imem_req    = r_imem_req;
   assign o_imem_addr   = r_pc;
   assign o_instr       = r_instr;
   assign o_instr_valid = r_instr_valid;
   assign o_pc          = r_pc;
   assign o_pc_plus4    = w_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign o_misalign    = r_misalign;
`else
   assign o_misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed table, hand sequences, random vs model.
module tb_fetch_pc_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_done;
   logic        jump, branch, nequal, jr, bclt, alu_zero, fp_cond;
   logic [31:0] jr_target;
   logic        misalign;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr),
      .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
      .o_instr(instr), .o_instr_valid(instr_valid),
      .o_pc(pc), .o_pc_plus4(pc_plus4),
      .i_instr_done(instr_done),
      .i_jump(jump), .i_branch(branch), .i_nequal(nequal), .i_jr(jr),
      .i_bclt(bclt), .i_alu_zero(alu_zero), .i_fp_cond(fp_cond),
      .i_jr_target(jr_target), .o_misalign(misalign)
   );

   typedef struct {
      logic [31:0] pc0;
      logic [31:0] ins;
      logic [6:0]  c;     // {jump, branch, nequal, jr, bclt, alu_zero, fp_cond}
      logic [31:0] jt;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic wait_req();
      int k = 0;
      while (imem_req !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("req_seen", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic set_ctrl(input logic [6:0] c, input logic [31:0] jt);
      {jump, branch, nequal, jr, bclt, alu_zero, fp_cond} = c;
      jr_target = jt;
   endtask

   // Starts at a negedge with imem_req=1; returns just after the retirement edge.
   task automatic exec_instr(input logic [31:0] ins, input int waits, input logic [31:0] pc_exp,
                             input logic [6:0] c, input logic [31:0] jt);
      imem_ack = 1'b0;
      for (int w = 0; w < waits; w++) @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = ins;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check("instr_valid", {31'd0, instr_valid}, 32'd1);
      check("instr", instr, ins);
      check("pc_plus4", pc_plus4, pc_exp + 32'd4);
      set_ctrl(c, jt);
      instr_done = 1'b1;
      @(negedge clk);
      instr_done = 1'b0;
      set_ctrl(7'd0, 32'd0);
   endtask

   task automatic set_pc(input logic [31:0] target);
      exec_instr(32'h0000_0000, 0, pc, 7'b0001000, target);
      wait_req();
      check("set_pc_addr", imem_addr, target);
   endtask

   // Reference next-PC from the architectural rules, using signed arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                              input logic [6:0] c, input logic [31:0] jt);
      logic [31:0] p4;
      int          off;
      bit          tk;
      p4  = p + 32'd4;
      off = int'($signed(ins[15:0])) * 4;
      tk  = (c[5] && (c[1] != c[4])) || (c[2] && (c[0] == ins[16]));
      if (c[3])      return jt & 32'hFFFF_FFFC;
      else if (c[6]) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      else if (tk)   return p4 + 32'(off);
      else           return p4;
   endfunction

   initial begin
      logic [31:0] rp, ri, rj, rexp;
      logic [6:0]  rc;

      vecs[0] = '{32'h0000_0200, 32'h0000_FFFF, 7'b0100010, 32'd0, 32'h0000_0200};
      vecs[1] = '{32'h0000_0200, 32'h0000_FFFF, 7'b0110010, 32'd0, 32'h0000_0204};
      vecs[2] = '{32'h3000_0010, 32'h0800_0040, 7'b1000000, 32'd0, 32'h3000_0100};
      vecs[3] = '{32'h3000_0010, 32'h0800_0040, 7'b1001000, 32'h400, 32'h0000_0400};
      vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 7'b0000000, 32'd0, 32'h0000_0000};
      vecs[5] = '{32'h0000_0010, 32'h0001_0002, 7'b0000101, 32'd0, 32'h0000_001C};
      vecs[6] = '{32'h0000_0010, 32'h0001_0002, 7'b0000100, 32'd0, 32'h0000_0014};
      vecs[7] = '{32'h0000_0200, 32'h0000_0010, 7'b0100000, 32'd0, 32'h0000_0204};
      vecs[8] = '{32'h0000_0010, 32'h0000_0002, 7'b0000100, 32'd0, 32'h0000_001C};
      vecs[9] = '{32'h0FFF_FFFC, 32'h0800_0001, 7'b1000000, 32'd0, 32'h1000_0004};

      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_done = 1'b0;
      set_ctrl(7'd0, 32'd0);

      // Reset held two cycles, then released.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_req", {31'd0, imem_req}, 32'd0);
         check("rst_valid", {31'd0, instr_valid}, 32'd0);
      end
      check("rst_pc", pc, RST_PC);
      check("rst_instr", instr, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, RST_PC);

      // Three wait cycles, then a late ack outside REQ must not disturb instr.
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         check("wait_req", {31'd0, imem_req}, 32'd1);
         check("wait_valid", {31'd0, instr_valid}, 32'd0);
      end
      imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
      @(negedge clk);
      check("t2_valid", {31'd0, instr_valid}, 32'd1);
      check("t2_req_low", {31'd0, imem_req}, 32'd0);
      imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      imem_ack = 1'b0;
      check("t2_instr", instr, 32'h2008_0005);
      instr_done = 1'b1;
      @(negedge clk);
      instr_done = 1'b0;
      check("t2_req", {31'd0, imem_req}, 32'd1);
      check("t2_next_addr", imem_addr, 32'h0000_0104);

      // Directed next-PC table.
      for (int v = 0; v < 10; v++) begin
         set_pc(vecs[v].pc0);
         exec_instr(vecs[v].ins, v % 3, vecs[v].pc0, vecs[v].c, vecs[v].jt);
         wait_req();
         check($sformatf("vec%0d_addr", v), imem_addr, vecs[v].exp);
      end

      // Randomized instructions against the reference model.
      for (int r = 0; r < 30; r++) begin
         rp = $urandom() & 32'hFFFF_FFFC;
         ri = $urandom();
         rc = 7'($urandom());
         rj = $urandom() & 32'hFFFF_FFFC;
         rexp = model_next(rp, ri, rc, rj);
         set_pc(rp);
         exec_instr(ri, $urandom_range(0, 2), rp, rc, rj);
         wait_req();
         check($sformatf("rnd%0d_addr", r), imem_addr, rexp);
      end

      // Misaligned jr target.
      set_pc(32'h0000_0300);
      exec_instr(32'h0000_0000, 0, 32'h0000_0300, 7'b0001000, 32'h0000_0402);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("mis_flag", {31'd0, misalign}, 32'd1);
      check("mis_pc_hold", pc, 32'h0000_0300);
      for (int h = 0; h < 5; h++) begin
         check("halt_req", {31'd0, imem_req}, 32'd0);
         check("halt_valid", {31'd0, instr_valid}, 32'd0);
         @(negedge clk);
      end
`else
      wait_req();
      check("mis_addr", imem_addr, 32'h0000_0400);
      check("mis_flag", {31'd0, misalign}, 32'd0);
`endif

      // Reset mid-REQ, ack arriving one cycle later is ignored.
      rst = 1'b1;
      @(negedge clk);
      check("mr_pc", pc, RST_PC);
      check("mr_misalign", {31'd0, misalign}, 32'd0);
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      @(negedge clk);
      imem_ack = 1'b0;
      check("mr_req", {31'd0, imem_req}, 32'd1);
      check("mr_valid", {31'd0, instr_valid}, 32'd0);
      check("mr_addr", imem_addr, RST_PC);
      check("mr_instr", instr, 32'd0);

      // Reset during EXEC with instr_done high wins.
      imem_ack = 1'b1; imem_rdata = 32'h0000_1111;
      @(negedge clk);
      imem_ack = 1'b0;
      set_ctrl(7'b0001000, 32'h0000_0600);
      instr_done = 1'b1; rst = 1'b1;
      @(negedge clk);
      check("re_pc", pc, RST_PC);
      check("re_valid", {31'd0, instr_valid}, 32'd0);
      check("re_req", {31'd0, imem_req}, 32'd0);
      rst = 1'b0; instr_done = 1'b0; set_ctrl(7'd0, 32'd0);
      @(negedge clk);
      check("re_addr", imem_addr, RST_PC);
      check("re_req2", {31'd0, imem_req}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
